// File: rtl/ttm4_alu_sequencer_if.sv
// Program-ROM handshake and ALU control/flag bundle for the TTM4 sequencer.
// master = sequencer side, slave = ROM/ALU side.
interface ttm4_alu_sequencer_if #(
   parameter int PC_W = 4
);
   logic            ROM_REQ;
   logic [PC_W-1:0] ROM_ADDR;
   logic            ROM_ACK;
   logic [7:0]      ROM_DATA;
   logic [3:0]      IM;
   logic [1:0]      SEL;
   logic            nFA_EN;
   logic            nAND_EN;
   logic            nOR_EN;
   logic            nXOR_EN;
   logic            A_LD;
   logic            B_LD;
   logic            OUT_LD;
   logic            Z_FLAG;
   logic            C_FLAG;

   modport master (
      output ROM_REQ, ROM_ADDR,
      input  ROM_ACK, ROM_DATA,
      output IM, SEL, nFA_EN, nAND_EN, nOR_EN, nXOR_EN, A_LD, B_LD, OUT_LD,
      input  Z_FLAG, C_FLAG
   );

   modport slave (
      input  ROM_REQ, ROM_ADDR,
      output ROM_ACK, ROM_DATA,
      input  IM, SEL, nFA_EN, nAND_EN, nOR_EN, nXOR_EN, A_LD, B_LD, OUT_LD,
      output Z_FLAG, C_FLAG
   );
endinterface

// File: rtl/ttm4_alu_sequencer.sv
// TTM4 fetch/execute controller: fetches 8-bit instructions, decodes ALU controls and jumps.
// Optional TTM4_SINGLE_STEP_EN adds a STEP input gating each fetch to one STEP rising edge.
module ttm4_alu_sequencer #(
   parameter int PC_W = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic RUN,
`ifdef TTM4_SINGLE_STEP_EN
   input  logic STEP,
`endif
   output logic HALTED,
   ttm4_alu_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pcNext;
   logic [7:0]      r_ir;
   logic [3:0]      w_op;
   logic [3:0]      w_imm;
   logic            w_fetchGo;
   logic            w_ackTake;
   logic            w_taken;

   assign w_op      = r_ir[7:4];
   assign w_imm     = r_ir[3:0];
   assign w_ackTake = (r_state == FETCH) && w_fetchGo && bus.ROM_ACK;

`ifdef TTM4_SINGLE_STEP_EN
   logic r_stepSync;
   logic r_stepQ;
   logic r_stepArmed;

   // One armed fetch per STEP rising edge, seen through a two-stage sample of STEP.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_stepSync  <= 1'b0;
         r_stepQ     <= 1'b0;
         r_stepArmed <= 1'b0;
      end else begin
         r_stepSync <= STEP;
         r_stepQ    <= r_stepSync;
         if (w_ackTake)
            r_stepArmed <= 1'b0;
         else if (r_stepSync && !r_stepQ && (r_state != HALT))
            r_stepArmed <= 1'b1;
      end
   end

   assign w_fetchGo = r_stepArmed;
`else
   assign w_fetchGo = 1'b1;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= IDLE;
         r_pc    <= '0;
         r_ir    <= 8'h00;
      end else begin
         r_state <= w_next;
         r_pc    <= w_pcNext;
         if (w_ackTake)
            r_ir <= bus.ROM_DATA;
      end
   end

   // Controls are purely a function of state and IR, so reset clears them at once.
   always_comb begin
      w_next       = r_state;
      w_pcNext     = r_pc;
      w_taken      = 1'b0;
      HALTED       = 1'b0;
      bus.ROM_REQ  = 1'b0;
      bus.ROM_ADDR = '0;
      bus.IM       = 4'h0;
      bus.SEL      = 2'b00;
      bus.nFA_EN   = 1'b1;
      bus.nAND_EN  = 1'b1;
      bus.nOR_EN   = 1'b1;
      bus.nXOR_EN  = 1'b1;
      bus.A_LD     = 1'b0;
      bus.B_LD     = 1'b0;
      bus.OUT_LD   = 1'b0;

      case (r_state)
         IDLE: begin
            if (RUN)
               w_next = FETCH;
         end

         FETCH: begin
            bus.ROM_REQ  = w_fetchGo;
            bus.ROM_ADDR = r_pc;
            if (w_ackTake)
               w_next = EXEC;
         end

         EXEC: begin
            bus.IM = w_imm;
            case (w_op)
               4'h0, 4'h1, 4'h2, 4'h3: begin
                  bus.SEL    = w_op[1:0];
                  bus.nFA_EN = 1'b0;
                  bus.A_LD   = 1'b1;
               end
               4'h4, 4'h5: begin
                  bus.SEL     = {1'b0, w_op[0]};
                  bus.nAND_EN = 1'b0;
                  bus.A_LD    = 1'b1;
               end
               4'h6, 4'h7: begin
                  bus.SEL    = {1'b0, w_op[0]};
                  bus.nOR_EN = 1'b0;
                  bus.A_LD   = 1'b1;
               end
               4'h8, 4'h9: begin
                  bus.SEL     = {1'b0, w_op[0]};
                  bus.nXOR_EN = 1'b0;
                  bus.A_LD    = 1'b1;
               end
               4'hA: w_taken = 1'b1;
               4'hB: w_taken = bus.Z_FLAG;
               4'hC: w_taken = bus.C_FLAG;
               4'hD: bus.B_LD = 1'b1;
               4'hE: bus.OUT_LD = 1'b1;
               default: ;
            endcase

            // HLT freezes the PC; everything else steps or jumps, wrapping at 2^PC_W.
            if (w_op == 4'hF) begin
               w_next = HALT;
            end else begin
               w_pcNext = w_taken ? PC_W'(w_imm) : r_pc + PC_W'(1);
               w_next   = RUN ? FETCH : IDLE;
            end
         end

         HALT: begin
            HALTED = 1'b1;
         end

         default: w_next = IDLE;
      endcase
   end

endmodule
